// File: rtl/fifo_stream_reader.sv
// Read-side engine for a pointer-based Fifo: drains entries into a registered
// 2-entry buffer and presents them as a val/rdy stream, with a flush sequence.
module fifo_stream_reader #(
    parameter type t_entry    = logic [31:0],
    parameter int  p_cnt_bits = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  t_entry                fifo_rdata,
    output logic                  fifo_pop,
    output t_entry                ostream_msg,
    output logic                  ostream_val,
    input  logic                  ostream_rdy,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [p_cnt_bits-1:0] xfer_count
);

    typedef enum logic [1:0] {ST_STREAM, ST_FLUSH, ST_DONE} state_t;

    state_t                state_q, state_d;
    t_entry                head_q, head_d;
    t_entry                tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic [p_cnt_bits-1:0] count_q, count_d;
    logic                  deq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STREAM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STREAM: if (flush) state_d = ST_FLUSH;
            ST_FLUSH:  if (fifo_empty) state_d = ST_DONE;
            ST_DONE:   state_d = ST_STREAM;
            default:   state_d = ST_STREAM;
        endcase
    end

    // Reset is folded in so a nonempty Fifo never sees a pop while held in reset.
    always_comb begin
        fifo_pop    = 1'b0;
        ostream_val = 1'b0;
        flush_done  = 1'b0;
        if (rst) begin
            case (state_q)
                ST_STREAM: begin
                    ostream_val = (occ_q != 2'd0) && !flush;
                    fifo_pop    = !fifo_empty && ((occ_q != 2'd2) || ostream_rdy) && !flush;
                end
                ST_FLUSH: fifo_pop   = !fifo_empty;
                ST_DONE:  flush_done = 1'b1;
                default: ;
            endcase
        end
    end

    assign deq = ostream_val && ostream_rdy;

    // Pops outside STREAM are discarded; a full buffer only pops alongside a dequeue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        count_d = count_q + {{(p_cnt_bits-1){1'b0}}, deq};
        if (state_q == ST_STREAM) begin
            if (flush) begin
                occ_d = 2'd0;
            end else begin
                case (occ_q)
                    2'd0: begin
                        if (fifo_pop) begin
                            head_d = fifo_rdata;
                            occ_d  = 2'd1;
                        end
                    end
                    2'd1: begin
                        if (fifo_pop && deq) begin
                            head_d = fifo_rdata;
                        end else if (fifo_pop) begin
                            tail_d = fifo_rdata;
                            occ_d  = 2'd2;
                        end else if (deq) begin
                            occ_d  = 2'd0;
                        end
                    end
                    2'd2: begin
                        if (deq) begin
                            head_d = tail_q;
                            if (fifo_pop) begin
                                tail_d = fifo_rdata;
                            end else begin
                                occ_d  = 2'd1;
                            end
                        end
                    end
                    default: occ_d = 2'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            count_q <= count_d;
        end
    end

    assign ostream_msg = head_q;
    assign xfer_count  = count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a Fifo model drives the DUT, a queue-based
// stream model predicts every cycle, and directed scenarios pin literal values.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        ostream_rdy = 1'b0;
    logic        flush = 1'b0;

    logic        fifo_pop, ostream_val, flush_done;
    logic [31:0] ostream_msg;
    logic [15:0] xfer_count;

    logic        s_pop, s_val, s_done;
    logic [31:0] s_msg;
    logic [3:0]  s_count;

    always #5 clk = ~clk;

    fifo_stream_reader u_dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_pop(fifo_pop), .ostream_msg(ostream_msg), .ostream_val(ostream_val),
        .ostream_rdy(ostream_rdy), .flush(flush), .flush_done(flush_done),
        .xfer_count(xfer_count)
    );

    fifo_stream_reader #(.p_cnt_bits(4)) u_small (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_pop(s_pop), .ostream_msg(s_msg), .ostream_val(s_val),
        .ostream_rdy(ostream_rdy), .flush(flush), .flush_done(s_done),
        .xfer_count(s_count)
    );

    // Upstream Fifo: pushes come from the stimulus, pops from the DUT.
    logic [31:0] fmem [0:63];
    int          fwr = 0;
    int          frd = 0;
    assign fifo_empty = (fwr == frd);
    assign fifo_rdata = fmem[frd[5:0]];
    always @(posedge clk) if (fifo_pop) frd <= frd + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] v);
        fmem[fwr[5:0]] = v;
        fwr++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stream model: queue of entries popped in stream mode and not yet delivered.
    typedef enum {M_STREAM, M_FLUSH, M_DONE} mmode_t;
    logic [31:0] mq[$];
    mmode_t      mmode = M_STREAM;
    logic [15:0] mcount = 16'd0;
    logic        e_val, e_pop, e_done;

    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            mmode  = M_STREAM;
            mcount = 16'd0;
            chk("rst_val", {31'd0, ostream_val}, 32'd0);
            chk("rst_pop", {31'd0, fifo_pop}, 32'd0);
            chk("rst_done", {31'd0, flush_done}, 32'd0);
            chk("rst_msg", ostream_msg, 32'd0);
            chk("rst_count", {16'd0, xfer_count}, 32'd0);
        end else begin
            e_val  = 1'b0;
            e_pop  = 1'b0;
            e_done = 1'b0;
            case (mmode)
                M_STREAM: begin
                    e_val = (mq.size() > 0) && !flush;
                    e_pop = !fifo_empty && ((mq.size() < 2) || ostream_rdy) && !flush;
                end
                M_FLUSH: e_pop = !fifo_empty;
                default: e_done = 1'b1;
            endcase
            chk("val", {31'd0, ostream_val}, {31'd0, e_val});
            chk("pop", {31'd0, fifo_pop}, {31'd0, e_pop});
            chk("done", {31'd0, flush_done}, {31'd0, e_done});
            chk("count", {16'd0, xfer_count}, {16'd0, mcount});
            chk("small_count", {28'd0, s_count}, {28'd0, mcount[3:0]});
            chk("small_val", {31'd0, s_val}, {31'd0, e_val});
            chk("small_pop", {31'd0, s_pop}, {31'd0, e_pop});
            chk("small_done", {31'd0, s_done}, {31'd0, e_done});
            if (e_val) begin
                chk("msg", ostream_msg, mq[0]);
                chk("small_msg", s_msg, mq[0]);
            end
            case (mmode)
                M_STREAM: begin
                    if (flush) begin
                        mq.delete();
                        mmode = M_FLUSH;
                    end else begin
                        if (e_val && ostream_rdy) begin
                            void'(mq.pop_front());
                            mcount = mcount + 16'd1;
                        end
                        if (e_pop) mq.push_back(fifo_rdata);
                    end
                end
                M_FLUSH: if (fifo_empty) mmode = M_DONE;
                default: mmode = M_STREAM;
            endcase
        end
    end

    initial begin
        bit seen;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);

        // Three entries with consumer ready: back-to-back delivery.
        ostream_rdy = 1'b1;
        push(32'hAAAA_0001); push(32'hAAAA_0002); push(32'hAAAA_0003);
        #1 chk("t1_pop0", {31'd0, fifo_pop}, 32'd1);
        step(1); chk("t1_msgA", ostream_msg, 32'hAAAA_0001); chk("t1_valA", {31'd0, ostream_val}, 32'd1);
        step(1); chk("t1_msgB", ostream_msg, 32'hAAAA_0002);
        step(1); chk("t1_msgC", ostream_msg, 32'hAAAA_0003);
        step(1); chk("t1_count", {16'd0, xfer_count}, 32'd3); chk("t1_val_idle", {31'd0, ostream_val}, 32'd0);

        // Consumer stalled: buffer fills with two, then stops popping.
        ostream_rdy = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h100 + i);
        step(2);
        chk("t2_pop_stall", {31'd0, fifo_pop}, 32'd0);
        chk("t2_val", {31'd0, ostream_val}, 32'd1);
        chk("t2_msg_e0", ostream_msg, 32'h100);
        chk("t2_fifo_left", fwr - frd, 32'd3);
        ostream_rdy = 1'b1;
        step(8);
        chk("t2_count", {16'd0, xfer_count}, 32'd8);

        // Full buffer with ready consumer: pop and dequeue every cycle.
        ostream_rdy = 1'b0;
        for (int i = 0; i < 14; i++) push(32'h200 + i);
        step(3);
        ostream_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_pop", {31'd0, fifo_pop}, 32'd1);
            chk("t3_val", {31'd0, ostream_val}, 32'd1);
            step(1);
        end
        step(8);
        chk("t3_count", {16'd0, xfer_count}, 32'd22);

        // Flush with two buffered and three in the Fifo.
        ostream_rdy = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h300 + i);
        step(2);
        flush = 1'b1;
        #1;
        chk("t4_val_flush", {31'd0, ostream_val}, 32'd0);
        chk("t4_pop_flush", {31'd0, fifo_pop}, 32'd0);
        step(1);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (flush_done) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        chk("t4_done_seen", {31'd0, seen}, 32'd1);
        chk("t4_fifo_drained", fwr - frd, 32'd0);
        step(1);
        chk("t4_done_pulse", {31'd0, flush_done}, 32'd0);
        chk("t4_count_kept", {16'd0, xfer_count}, 32'd22);
        ostream_rdy = 1'b1;
        push(32'h55);
        step(1);
        chk("t4_msg55", ostream_msg, 32'h55);
        chk("t4_val55", {31'd0, ostream_val}, 32'd1);
        step(1);
        chk("t4_count55", {16'd0, xfer_count}, 32'd23);

        // Asynchronous reset between edges with a full buffer.
        ostream_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h400 + i);
        step(2);
        #2 rst = 1'b0;
        #1;
        chk("t5_val", {31'd0, ostream_val}, 32'd0);
        chk("t5_pop", {31'd0, fifo_pop}, 32'd0);
        chk("t5_msg", ostream_msg, 32'd0);
        chk("t5_count", {16'd0, xfer_count}, 32'd0);
        step(1);
        rst = 1'b1;
        ostream_rdy = 1'b1;
        #1 chk("t5_resume_pop", {31'd0, fifo_pop}, 32'd1);
        step(1);
        chk("t5_resume_msg", ostream_msg, 32'h402);

        // Seventeen handshakes since reset: 4-bit counter wraps to 1.
        for (int i = 0; i < 15; i++) push(32'h500 + i);
        step(25);
        chk("t6_count16", {16'd0, xfer_count}, 32'd17);
        chk("t6_count4", {28'd0, s_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
